// File: rtl/popcount_seq_ctrl.sv
// popcount_seq_ctrl: counts the set bits of an NBYTES-byte vector by feeding
// one byte per clock through a single 8-bit ones-count slice and accumulating.
// start/busy/done handshake; the final total is held on ones_out until the
// next completion.
// Optional build macro POPCOUNT_EARLY_EXIT_EN: finish as soon as the remaining
// bytes are all zero (result value is unchanged, only latency shrinks).
module popcount_seq_ctrl #(
    parameter int NBYTES = 4,
    parameter int CW     = 6,
    localparam int IW    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   data_in,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         ones_out,
    output logic [IW-1:0]         byte_idx
);

    localparam int SW = 8 * NBYTES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   acc_q,   acc_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [CW-1:0]   ones_q,  ones_d;

    logic [3:0]      byte_ones;
    logic [CW-1:0]   sum;
    logic [SW-1:0]   shifted;
    logic            last_byte;
    logic            finish;

    // Ones count of the byte currently at the bottom of the shift register.
    always_comb begin
        byte_ones = 4'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            byte_ones = byte_ones + {3'b000, shift_q[i]};
        end
    end

    // Running total including the current byte, and the completion condition.
    always_comb begin
        sum       = acc_q + CW'(byte_ones);
        shifted   = shift_q >> 8;
        last_byte = (idx_q == IW'(NBYTES - 1));
`ifdef POPCOUNT_EARLY_EXIT_EN
        finish    = last_byte || (shifted == '0);
`else
        finish    = last_byte;
`endif
    end

    // Next-state and datapath update for the IDLE/COUNT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shift_d = data_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                acc_d   = sum;
                shift_d = shifted;
                if (finish) begin
                    // byte_idx holds on the final byte so it never wraps mid-operation.
                    ones_d  = sum;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
        end
    end

    assign busy     = (state_q == COUNT);
    assign done     = (state_q == DONE);
    assign ones_out = ones_q;
    assign byte_idx = idx_q;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Testbench for popcount_seq_ctrl: a 4-byte instance and a 1-byte instance,
// expected totals queued at stimulus time and compared at the done pulse.
module tb_popcount_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;

    logic        start4;
    logic [31:0] data4;
    logic        busy4, done4;
    logic [5:0]  ones4;
    logic [1:0]  idx4;

    logic        start1;
    logic [7:0]  data1;
    logic        busy1, done1;
    logic [3:0]  ones1;
    logic [0:0]  idx1;

    int checks = 0;
    int passed = 0;

    logic [5:0] sb4[$];
    logic [3:0] sb1[$];

    always #5 clk = ~clk;

    popcount_seq_ctrl #(.NBYTES(4), .CW(6)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .data_in(data4),
        .busy(busy4), .done(done4), .ones_out(ones4), .byte_idx(idx4)
    );

    popcount_seq_ctrl #(.NBYTES(1), .CW(4)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .data_in(data1),
        .busy(busy1), .done(done1), .ones_out(ones1), .byte_idx(idx1)
    );

    // Expected start-edge-to-done latency of the 4-byte instance.
    function automatic int exp_lat4(input logic [31:0] v);
`ifdef POPCOUNT_EARLY_EXIT_EN
        int m;
        m = 0;
        for (int b = 0; b < 4; b++) if (v[8*b +: 8] != 8'h00) m = b;
        return m + 2;
`else
        return 5;
`endif
    endfunction

    // Issue one operation on the 4-byte instance and wait (bounded) for done.
    task automatic op4(input logic [31:0] v, output int lat, output int bc,
                       output bit seen, output logic [5:0] got, output logic busy_at_done);
        @(negedge clk);
        start4 = 1'b1;
        data4  = v;
        sb4.push_back(6'($countones(v)));
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        bc  = 0;
        while (!done4 && lat < 40) begin
            if (busy4) bc++;
            data4 = $urandom;
            @(negedge clk);
            lat++;
        end
        seen = done4;
        got  = ones4;
        busy_at_done = busy4;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        start4 = 1'b0; data4 = '0;
        start1 = 1'b0; data1 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, ones4, idx4} !== 10'd0)
            $display("FAIL reset4: busy=%b done=%b ones=%0d idx=%0d, required all 0", busy4, done4, ones4, idx4);
        else passed++;
        checks++;
        if ({busy1, done1, ones1, idx1} !== 7'd0)
            $display("FAIL reset1: busy=%b done=%b ones=%0d idx=%0d, required all 0", busy1, done1, ones1, idx1);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy4, done4, ones4} !== 8'd0)
            $display("FAIL idle_after_reset: busy=%b done=%b ones=%0d, required 0", busy4, done4, ones4);
        else passed++;
    endtask

    task automatic test_all_ones;
        int lat, bc; bit seen; logic [5:0] got, exp; logic bd;
        op4(32'hFFFF_FFFF, lat, bc, seen, got, bd);
        checks++;
        if (!seen) $display("FAIL all_ones_done: no done within %0d cycles", lat);
        else passed++;
        checks++;
        if (lat !== exp_lat4(32'hFFFF_FFFF)) $display("FAIL all_ones_lat: got %0d, required %0d", lat, exp_lat4(32'hFFFF_FFFF));
        else passed++;
        checks++;
        if (bc !== 4) $display("FAIL all_ones_busy_cycles: got %0d, required 4", bc);
        else passed++;
        checks++;
        if (bd !== 1'b0) $display("FAIL all_ones_busy_at_done: got %b, required 0", bd);
        else passed++;
        exp = sb4.pop_front();
        checks++;
        if (got !== exp) $display("FAIL all_ones_value: got %0d, required %0d", got, exp);
        else passed++;
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0 || ones4 !== exp) $display("FAIL all_ones_hold: done=%b ones=%0d, required done=0 ones=%0d", done4, ones4, exp);
        else passed++;
    endtask

    task automatic test_mixed;
        int lat, bc; bit seen; logic [5:0] got, exp; logic bd;
        op4(32'h8001_0F00, lat, bc, seen, got, bd);
        checks++;
        if (!seen || lat !== exp_lat4(32'h8001_0F00))
            $display("FAIL mixed_lat: seen=%b lat=%0d, required lat %0d", seen, lat, exp_lat4(32'h8001_0F00));
        else passed++;
        exp = sb4.pop_front();
        checks++;
        if (got !== exp) $display("FAIL mixed_value: got %0d, required %0d", got, exp);
        else passed++;
    endtask

    task automatic test_zero;
        int lat, bc; bit seen; logic [5:0] got, exp; logic bd;
        op4(32'h0000_0000, lat, bc, seen, got, bd);
        checks++;
        if (!seen || lat !== exp_lat4(32'h0))
            $display("FAIL zero_lat: seen=%b lat=%0d, required lat %0d", seen, lat, exp_lat4(32'h0));
        else passed++;
        exp = sb4.pop_front();
        checks++;
        if (got !== exp) $display("FAIL zero_value: got %0d, required %0d", got, exp);
        else passed++;
        checks++;
        if (bc !== lat - 1) $display("FAIL zero_busy_cycles: got %0d, required %0d", bc, lat - 1);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        logic [5:0]  exp;
        int lat;
        v = 32'h0000_00FF;
        @(negedge clk);
        start4 = 1'b1;
        data4  = v;
        sb4.push_back(6'($countones(v)));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat = 1;
            while (!done4 && lat < 40) begin
                data4 = $urandom;
                @(negedge clk);
                lat++;
            end
            checks++;
            if (!done4 || lat !== exp_lat4(v))
                $display("FAIL b2b_lat[%0d]: done=%b lat=%0d, required lat %0d", i, done4, lat, exp_lat4(v));
            else passed++;
            exp = sb4.pop_front();
            checks++;
            if (ones4 !== exp) $display("FAIL b2b_value[%0d]: got %0d, required %0d", i, ones4, exp);
            else passed++;
            if (i < 3) begin
                v = (v == 32'h0000_00FF) ? 32'h0101_0101 : 32'h0000_00FF;
                data4 = v;
                sb4.push_back(6'($countones(v)));
            end else begin
                start4 = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_count;
        int lat, bc, n; bit seen; logic [5:0] got, exp; logic bd;
        @(negedge clk);
        start4 = 1'b1;
        data4  = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (idx4 !== 2'd2 || busy4 !== 1'b1) $display("FAIL abort_point: idx=%0d busy=%b, required idx=2 busy=1", idx4, busy4);
        else passed++;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy4, done4, ones4, idx4} !== 10'd0)
            $display("FAIL abort_clear: busy=%b done=%b ones=%0d idx=%0d, required all 0", busy4, done4, ones4, idx4);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) n++;
        end
        checks++;
        if (n !== 0) $display("FAIL abort_no_done: saw %0d done cycles, required 0", n);
        else passed++;
        op4(32'h0000_0003, lat, bc, seen, got, bd);
        exp = sb4.pop_front();
        checks++;
        if (!seen || got !== exp || lat !== exp_lat4(32'h3))
            $display("FAIL after_abort: seen=%b ones=%0d lat=%0d, required ones=%0d lat=%0d", seen, got, lat, exp, exp_lat4(32'h3));
        else passed++;
    endtask

    task automatic test_single_byte;
        logic [3:0] exp;
        int lat;
        @(negedge clk);
        start1 = 1'b1;
        data1  = 8'hA5;
        sb1.push_back(4'($countones(8'hA5)));
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        data1  = 8'hFF;
        lat = 1;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        exp = sb1.pop_front();
        checks++;
        if (!done1 || lat !== 2) $display("FAIL nb1_lat: done=%b lat=%0d, required lat 2", done1, lat);
        else passed++;
        checks++;
        if (ones1 !== exp || idx1 !== 1'b0) $display("FAIL nb1_value: ones=%0d idx=%0d, required ones=%0d idx=0", ones1, idx1, exp);
        else passed++;
        start1 = 1'b1;
        data1  = 8'h00;
        sb1.push_back(4'd0);
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        data1  = 8'hFF;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) $display("FAIL nb1_b2b_accept: busy=%b done=%b, required busy=1 done=0", busy1, done1);
        else passed++;
        lat = 1;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        exp = sb1.pop_front();
        checks++;
        if (!done1 || lat !== 2 || ones1 !== exp)
            $display("FAIL nb1_b2b: done=%b lat=%0d ones=%0d, required lat=2 ones=%0d", done1, lat, ones1, exp);
        else passed++;
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || ones1 !== exp) $display("FAIL nb1_pulse: done=%b ones=%0d, required done=0 ones=%0d", done1, ones1, exp);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_all_ones;
        test_mixed;
        test_zero;
        test_back_to_back;
        test_reset_mid_count;
        test_single_byte;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
